// File: rtl/spi_adc_scanner.sv
// Round-robin SPI ADC scanner: timed frames, command out on MOSI, DATA_W-bit result in from MISO.
// Optional ADC_AVG_EN: publish the mean of every four conversions per channel instead of each one.
//   state | meaning
//   IDLE  | waiting for sample tick with EN high
//   SETUP | CS_N low, SCK low, first command bit on MOSI
//   SHIFT | SCK toggling, MISO sampled on rise, MOSI advanced on fall
//   DONE  | CS_N high, result published
//   HOLD  | minimum deselect time before next frame
module spi_adc_scanner #(
    parameter int DATA_W        = 12,
    parameter int NUM_CH        = 2,
    parameter int CH_BITS       = 1,
    parameter int FRAME_BITS    = 16,
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               MISO,
    output logic               MOSI,
    output logic               SCK,
    output logic               CS_N,
    output logic [DATA_W-1:0]  value,
    output logic [CH_BITS-1:0] chan,
    output logic               valid,
    output logic               busy,
    output logic               overrun
);

    localparam int TMR_W = $clog2(SAMPLE_PERIOD);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, HOLD} state_t;

    state_t                 state, state_next;
    logic [TMR_W-1:0]       tmr;
    logic [DIV_W-1:0]       div_cnt;
    logic [BIT_W-1:0]       rise_cnt;
    logic                   sck_q;
    logic [FRAME_BITS-1:0]  cmd_sr;
    logic [FRAME_BITS-1:0]  cmd_word;
    logic [DATA_W-1:0]      rx_sr;
    logic [CH_BITS-1:0]     cur_ch;
    logic [CH_BITS-1:0]     next_ch;
    logic                   tick;
    logic                   div_zero;
    logic                   start;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   frame_end;

    assign tick      = (tmr == TMR_W'(SAMPLE_PERIOD - 1));
    assign div_zero  = (div_cnt == '0);
    assign start     = (state == IDLE) && tick && EN;
    assign sck_rise  = div_zero && !sck_q && ((state == SETUP) || (state == SHIFT));
    assign sck_fall  = div_zero && sck_q && (state == SHIFT);
    assign frame_end = sck_fall && (rise_cnt == BIT_W'(FRAME_BITS));

    assign CS_N = !((state == SETUP) || (state == SHIFT));
    assign busy = (state == SETUP) || (state == SHIFT) || (state == DONE);
    assign SCK  = sck_q;
    assign MOSI = !CS_N && cmd_sr[FRAME_BITS-1];

    // Frame sent MSB-first: start, single-ended, channel, zero padding.
    always_comb begin
        cmd_word = '0;
        cmd_word[FRAME_BITS-1] = 1'b1;
        cmd_word[FRAME_BITS-2] = 1'b1;
        cmd_word[FRAME_BITS-3 -: CH_BITS] = next_ch;
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = SETUP;
            SETUP:   if (div_zero)  state_next = SHIFT;
            SHIFT:   if (frame_end) state_next = DONE;
            DONE:                   state_next = HOLD;
            HOLD:    if (div_zero)  state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tmr      <= '0;
            div_cnt  <= '0;
            rise_cnt <= '0;
            sck_q    <= 1'b0;
            cmd_sr   <= '0;
            rx_sr    <= '0;
            cur_ch   <= '0;
            next_ch  <= '0;
            overrun  <= 1'b0;
        end else begin
            tmr     <= tick ? '0 : tmr + TMR_W'(1);
            overrun <= tick && (state != IDLE);
            div_cnt <= ((state == IDLE) || (state == DONE) || div_zero) ? DIV_MAX
                                                                       : div_cnt - DIV_W'(1);
            if (start) begin
                cur_ch   <= next_ch;
                cmd_sr   <= cmd_word;
                rise_cnt <= '0;
            end
            if (sck_rise) begin
                sck_q    <= 1'b1;
                rx_sr    <= DATA_W'({rx_sr, MISO});
                rise_cnt <= rise_cnt + BIT_W'(1);
            end
            if (sck_fall) begin
                sck_q  <= 1'b0;
                cmd_sr <= {cmd_sr[FRAME_BITS-2:0], 1'b0};
            end
            if (frame_end)
                next_ch <= (cur_ch == CH_BITS'(NUM_CH - 1)) ? '0 : cur_ch + CH_BITS'(1);
        end
    end

`ifdef ADC_AVG_EN
    logic [DATA_W+1:0] acc   [NUM_CH];
    logic [1:0]        acc_n [NUM_CH];
    logic [DATA_W+1:0] acc_sum;

    assign acc_sum = acc[cur_ch] + (DATA_W+2)'(rx_sr);

    always_ff @(posedge CLK) begin
        if (RST) begin
            value <= '0;
            chan  <= '0;
            valid <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i]   <= '0;
                acc_n[i] <= '0;
            end
        end else begin
            valid <= 1'b0;
            if (frame_end) begin
                if (acc_n[cur_ch] == 2'd3) begin
                    value         <= acc_sum[DATA_W+1:2];
                    chan          <= cur_ch;
                    valid         <= 1'b1;
                    acc[cur_ch]   <= '0;
                    acc_n[cur_ch] <= '0;
                end else begin
                    acc[cur_ch]   <= acc_sum;
                    acc_n[cur_ch] <= acc_n[cur_ch] + 2'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (RST) begin
            value <= '0;
            chan  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (frame_end) begin
                value <= rx_sr;
                chan  <= cur_ch;
                valid <= 1'b1;
            end
        end
    end
`endif

endmodule
